// File: rtl/riscv_fetch_top_if.sv
// Debug/observation bundle of the RV32I fetch stage.
// The fetch stage drives it as master; a decode stage or bench reads it as slave.
interface riscv_fetch_top_if;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic [31:0] fetch_count_o;

    modport master (
        output pc_o,
        output if_id_pc_o,
        output if_id_instr_o,
        output if_id_valid_o,
        output fetch_count_o
    );

    modport slave (
        input pc_o,
        input if_id_pc_o,
        input if_id_instr_o,
        input if_id_valid_o,
        input fetch_count_o
    );
endinterface

// File: rtl/riscv_fetch_top.sv
// RV32I instruction-fetch stage: PC, PC+4, built-in ROM program and the IF/ID register.
// Optional IF_JAL_REDIRECT_EN: predecode JAL in fetch and redirect the next PC to its target.
module riscv_fetch_top #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    riscv_fetch_top_if.master dbg
);
    localparam int          IDX_W = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      r_pc;
    logic [31:0]      r_if_id_pc;
    logic [31:0]      r_if_id_instr;
    logic             r_if_id_valid;
    logic [31:0]      r_fetch_count;

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_instr;
    logic [31:0]      w_next_pc;

    // Upper PC bits are dropped, so addresses alias modulo the ROM size.
    assign w_idx = r_pc[IDX_W+1:2];

    always_comb begin
        w_instr = NOP;
        case (w_idx)
            IDX_W'(0): w_instr = 32'h0050_0093;
            IDX_W'(1): w_instr = 32'h00A0_0113;
            IDX_W'(2): w_instr = 32'h0020_81B3;
            IDX_W'(3): w_instr = 32'h4020_8233;
            IDX_W'(4): w_instr = 32'h0000_0013;
            IDX_W'(5): w_instr = 32'hFEDF_F06F;
            default:   w_instr = NOP;
        endcase
    end

`ifdef IF_JAL_REDIRECT_EN
    logic [31:0] w_jal_imm;
    logic        w_is_jal;

    assign w_jal_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                        w_instr[20], w_instr[30:21], 1'b0};
    assign w_is_jal  = (w_instr[6:0] == 7'b1101111);
    assign w_next_pc = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
`else
    assign w_next_pc = r_pc + 32'd4;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_instr <= NOP;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            r_pc          <= w_next_pc;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= w_instr;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign dbg.pc_o          = r_pc;
    assign dbg.if_id_pc_o    = r_if_id_pc;
    assign dbg.if_id_instr_o = r_if_id_instr;
    assign dbg.if_id_valid_o = r_if_id_valid;
    assign dbg.fetch_count_o = r_fetch_count;
endmodule

// File: tb/tb_riscv_fetch_top.sv
// Bench for riscv_fetch_top: directed fetch sequence plus random run lengths and
// random reset pulses, checked against an address-level model of the fetch stage.
module tb_riscv_fetch_top;
    localparam int DEPTH = 64;

    logic clk;
    logic reset;

    riscv_fetch_top_if dbg_if ();

    riscv_fetch_top #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dbg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_cnt;

    function automatic logic [31:0] imem_ref(input logic [31:0] addr);
        return prog[(addr / 4) % DEPTH];
    endfunction

    // Target offset of a JAL computed arithmetically from its immediate fields.
    function automatic logic [31:0] jal_offset(input logic [31:0] ins);
        int off;
        off = 0;
        if (ins[31]) off = off - (1 << 20);
        off = off + int'(ins[19:12]) * 4096;
        off = off + int'(ins[20]) * 2048;
        off = off + int'(ins[30:21]) * 2;
        return 32'(off);
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ifpc  = 32'h0;
        m_instr = 32'h0000_0013;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] ins;
        ins     = imem_ref(m_pc);
        m_ifpc  = m_pc;
        m_instr = ins;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
`ifdef IF_JAL_REDIRECT_EN
        if (ins[6:0] == 7'h6F) m_pc = m_pc + jal_offset(ins);
        else                   m_pc = m_pc + 32'd4;
`else
        m_pc = m_pc + 32'd4;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string where);
        chk({where, " pc_o"},          dbg_if.pc_o,          m_pc);
        chk({where, " if_id_pc_o"},    dbg_if.if_id_pc_o,    m_ifpc);
        chk({where, " if_id_instr_o"}, dbg_if.if_id_instr_o, m_instr);
        chk({where, " if_id_valid_o"}, {31'b0, dbg_if.if_id_valid_o}, {31'b0, m_valid});
        chk({where, " fetch_count_o"}, dbg_if.fetch_count_o, m_cnt);
    endtask

    task automatic run_edges(input int n, input string where);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk_all(where);
        end
    endtask

    // Assert reset just after a falling edge, check it takes effect without a clock,
    // optionally hold it across further edges, then release mid low-phase.
    task automatic reset_pulse(input int extra_cycles, input int rel_delay, input string where);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all({where, " async"});
        for (int i = 0; i < extra_cycles; i++) begin
            @(negedge clk);
            chk_all({where, " held"});
        end
        #(rel_delay);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'h0000_0013;
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h4020_8233;
        prog[4] = 32'h0000_0013;
        prog[5] = 32'hFEDF_F06F;

        // Reset asserted from time zero: visible before the first clock edge.
        reset = 1'b1;
        model_reset();
        #2;
        chk_all("reset_no_edge");
        #16;
        chk_all("reset_held");
        @(negedge clk);
        #2;
        reset = 1'b0;

        run_edges(1, "seq");
        chk("e1 pc_o", dbg_if.pc_o, 32'h0000_0004);
        chk("e1 if_id_pc_o", dbg_if.if_id_pc_o, 32'h0000_0000);
        chk("e1 if_id_instr_o", dbg_if.if_id_instr_o, 32'h0050_0093);
        run_edges(1, "seq");
        chk("e2 pc_o", dbg_if.pc_o, 32'h0000_0008);
        chk("e2 if_id_instr_o", dbg_if.if_id_instr_o, 32'h00A0_0113);
        run_edges(2, "seq");
        chk("e4 if_id_instr_o", dbg_if.if_id_instr_o, 32'h4020_8233);
        chk("e4 fetch_count_o", dbg_if.fetch_count_o, 32'd4);
        run_edges(2, "seq");
        chk("e6 if_id_pc_o", dbg_if.if_id_pc_o, 32'h0000_0014);
        chk("e6 if_id_instr_o", dbg_if.if_id_instr_o, 32'hFEDF_F06F);
`ifdef IF_JAL_REDIRECT_EN
        chk("e6 pc_o", dbg_if.pc_o, 32'h0000_0000);
        run_edges(1, "seq");
        chk("e7 if_id_instr_o", dbg_if.if_id_instr_o, 32'h0050_0093);
        chk("e7 if_id_pc_o", dbg_if.if_id_pc_o, 32'h0000_0000);
        run_edges(6, "loop");
        chk("e13 if_id_pc_o", dbg_if.if_id_pc_o, 32'h0000_0000);
        chk("e13 if_id_instr_o", dbg_if.if_id_instr_o, 32'h0050_0093);
`else
        chk("e6 pc_o", dbg_if.pc_o, 32'h0000_0018);
        run_edges(58, "nop_run");
        chk("e64 pc_o", dbg_if.pc_o, 32'h0000_0100);
        chk("e64 if_id_instr_o", dbg_if.if_id_instr_o, 32'h0000_0013);
        run_edges(1, "alias");
        chk("e65 if_id_instr_o", dbg_if.if_id_instr_o, 32'h0050_0093);
        chk("e65 if_id_pc_o", dbg_if.if_id_pc_o, 32'h0000_0100);
`endif

        // Mid-run reset: three edges in, a 3-unit pulse between clock edges.
        reset_pulse(0, 2, "rst_a");
        run_edges(3, "pre_mid");
        reset_pulse(0, 2, "mid_rst");
        run_edges(1, "post_mid");
        chk("mid first instr", dbg_if.if_id_instr_o, 32'h0050_0093);
        chk("mid first pc", dbg_if.if_id_pc_o, 32'h0000_0000);

        reset_pulse(1, 2, "cnt_rst");
        run_edges(20, "count");
        chk("cnt20 fetch_count_o", dbg_if.fetch_count_o, 32'd20);
`ifdef IF_JAL_REDIRECT_EN
        chk("cnt20 pc_o", dbg_if.pc_o, 32'h0000_0008);
`else
        chk("cnt20 pc_o", dbg_if.pc_o, 32'h0000_0050);
`endif

        for (int it = 0; it < 10; it++) begin
            run_edges(int'($urandom_range(1, 40)), "rand_run");
            reset_pulse(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), "rand_rst");
        end
        run_edges(int'($urandom_range(70, 90)), "rand_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
